// File: rtl/fft32_seq_ctrl.sv
// Sequencer for a streaming FFT core: loads a frame of samples, runs the
// butterfly pipeline for its latency, then unloads results in bit-reversed order.
module fft32_seq_ctrl #(
  parameter int p_points    = 32,
  parameter int p_addrBits  = 5,
  parameter int p_latency   = 4,
  parameter int p_bitRev    = 1,
  parameter int p_frameBits = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_inValid,
  output logic                   o_inReady,
  output logic                   o_wrEn,
  output logic [p_addrBits-1:0]  o_wrAddr,
  output logic                   o_run,
  output logic [p_addrBits-1:0]  o_rdAddr,
  output logic                   o_outValid,
  input  logic                   i_outReady,
  output logic                   o_outLast,
  output logic                   o_busy,
  output logic                   o_frameDone,
  output logic [p_frameBits-1:0] o_frameCnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  localparam logic [p_addrBits-1:0] CNT_LAST = p_addrBits'(p_points - 1);
  localparam logic [p_addrBits-1:0] LAT_LAST = p_addrBits'(p_latency - 1);

  state_t                state_q;
  state_t                state_d;
  logic [p_addrBits-1:0] cnt_q;
  logic [p_addrBits-1:0] cnt_d;
  logic [p_addrBits-1:0] cnt_rev;
  logic                  frame_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      o_frameDone <= 1'b0;
      o_frameCnt  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_frameDone <= frame_end;
      if (frame_end)
        o_frameCnt <= o_frameCnt + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_end  = 1'b0;
    o_inReady  = 1'b0;
    o_wrEn     = 1'b0;
    o_outValid = 1'b0;
    o_run      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        o_inReady = 1'b1;
        if (i_inValid) begin
          o_wrEn = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end
        end
      end
      COMPUTE: begin
        o_run = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT_LAST) begin
          state_d = UNLOAD;
          cnt_d   = '0;
        end
      end
      UNLOAD: begin
        o_outValid = 1'b1;
        if (i_outReady) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            frame_end = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort voids any handshake that coincides with it
    if (i_abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      frame_end  = 1'b0;
      o_inReady  = 1'b0;
      o_wrEn     = 1'b0;
      o_outValid = 1'b0;
    end
  end

  always_comb begin
    cnt_rev = '0;
    for (int b = 0; b < p_addrBits; b++)
      cnt_rev[b] = cnt_q[p_addrBits-1-b];
  end

  assign o_wrAddr  = cnt_q;
  assign o_rdAddr  = (p_bitRev != 0) ? cnt_rev : cnt_q;
  assign o_outLast = (state_q == UNLOAD) && (cnt_q == CNT_LAST);
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// Scoreboard bench for fft32_seq_ctrl: expected writes, reads and frame
// completions are queued by the stimulus and checked by a negedge monitor.
module tb_fft32_seq_ctrl;

  logic       CLK = 0;
  logic       RST = 1;
  logic       i_start = 0;
  logic       i_abort = 0;
  logic       i_inValid = 0;
  logic       i_outReady = 0;
  logic       o_inReady, o_wrEn, o_run, o_outValid;
  logic       o_outLast, o_busy, o_frameDone;
  logic [4:0] o_wrAddr, o_rdAddr;
  logic [7:0] o_frameCnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] wr_q[$];
  logic [5:0] rd_q[$];
  logic [7:0] done_q[$];
  logic [7:0] fcnt_m = 0;
  bit         stall_prev = 0;
  logic [4:0] stall_addr = 0;

  fft32_seq_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_inValid(i_inValid),
    .o_inReady(o_inReady),
    .o_wrEn(o_wrEn),
    .o_wrAddr(o_wrAddr),
    .o_run(o_run),
    .o_rdAddr(o_rdAddr),
    .o_outValid(o_outValid),
    .i_outReady(i_outReady),
    .o_outLast(o_outLast),
    .o_busy(o_busy),
    .o_frameDone(o_frameDone),
    .o_frameCnt(o_frameCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] brev(input logic [4:0] a);
    for (int b = 0; b < 5; b++) brev[b] = a[4-b];
  endfunction

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) wr_q.push_back(5'(i));
  endtask

  task automatic push_reads();
    for (int i = 0; i < 32; i++) rd_q.push_back({brev(5'(i)), i == 31});
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (stall_prev && o_outValid) chk("rd_stable", o_rdAddr, stall_addr);
      stall_prev = o_outValid && !i_outReady;
      stall_addr = o_rdAddr;
      if (o_wrEn) begin
        if (wr_q.size() == 0) chk("wr_unexpected", o_wrEn, 0);
        else chk("wr_addr", o_wrAddr, wr_q.pop_front());
      end
      if (o_outValid && i_outReady) begin
        if (rd_q.size() == 0) chk("rd_unexpected", o_outValid, 0);
        else chk("rd_addr_last", {o_rdAddr, o_outLast}, rd_q.pop_front());
      end
      if (o_frameDone) begin
        if (done_q.size() == 0) chk("done_unexpected", o_frameDone, 0);
        else chk("frame_cnt", o_frameCnt, done_q.pop_front());
      end
    end else begin
      stall_prev = 0;
    end
  end

  task automatic frame(input bit gaps, input bit lat, input bit noise);
    int cyc, nwr, nrd, nrun;
    bit done;
    cyc = 0; nwr = 0; nrd = 0; nrun = 0; done = 0;
    push_writes(32);
    push_reads();
    fcnt_m = fcnt_m + 1;
    done_q.push_back(fcnt_m);
    #1;
    i_start = 1;
    @(posedge CLK); #1;
    i_start = 0;
    for (int k = 0; k < 2000; k++) begin
      i_inValid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_outReady = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_start    = noise && (nrd < 16) && ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      cyc++;
      if (o_wrEn) nwr++;
      if (o_run) nrun++;
      if (o_outValid && i_outReady) nrd++;
      if (o_frameDone) begin
        done = 1;
        break;
      end
      @(posedge CLK); #1;
    end
    #1;
    i_start = 0; i_inValid = 0; i_outReady = 0;
    if (!done) chk("frame_timeout", done, 1);
    chk("n_writes", nwr, 32);
    chk("n_reads", nrd, 32);
    chk("n_run", nrun, 4);
    if (lat) chk("latency", cyc, 69);
  endtask

  initial begin
    #1 RST = 0;
    #2;
    chk("reset_outs", {o_inReady, o_wrEn, o_run, o_outValid, o_outLast,
                       o_busy, o_frameDone, o_wrAddr, o_rdAddr, o_frameCnt}, 0);
    @(negedge CLK) RST = 1;
    @(negedge CLK);
    chk("idle_busy", o_busy, 0);

    frame(0, 1, 0);
    frame(1, 0, 0);
    chk("cnt_after_2", o_frameCnt, 2);

    // Abort with the 18th sample (address 17) offered
    push_writes(17);
    #1 i_start = 1;
    @(posedge CLK); #1;
    i_start = 0; i_inValid = 1;
    repeat (17) @(posedge CLK);
    #1 i_abort = 1;
    #1;
    chk("abort_inready", o_inReady, 0);
    chk("abort_wren", o_wrEn, 0);
    @(posedge CLK); #1;
    i_abort = 0; i_inValid = 0;
    chk("abort_idle", o_busy, 0);
    chk("abort_wraddr", o_wrAddr, 0);
    chk("abort_fcnt", o_frameCnt, fcnt_m);
    frame(0, 0, 0);

    // Abort coinciding with the final output handshake
    push_writes(32);
    push_reads();
    #1 i_start = 1;
    @(posedge CLK); #1;
    i_start = 0; i_inValid = 1; i_outReady = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (o_outValid && o_outLast) break;
      @(posedge CLK); #1;
    end
    #1 i_abort = 1;
    #1;
    chk("abort_last_valid", o_outValid, 0);
    chk("abort_last_busy", o_busy, 1);
    @(posedge CLK); #1;
    i_abort = 0; i_inValid = 0; i_outReady = 0;
    chk("abort_last_idle", o_busy, 0);
    @(negedge CLK);
    chk("abort_last_done", o_frameDone, 0);
    chk("abort_last_fcnt", o_frameCnt, fcnt_m);

    // Start together with abort in IDLE
    #1 i_start = 1; i_abort = 1;
    @(posedge CLK); #1;
    i_start = 0; i_abort = 0;
    chk("start_abort_idle", o_busy, 0);

    // Reset pulse during COMPUTE
    push_writes(32);
    #1 i_start = 1;
    @(posedge CLK); #1;
    i_start = 0; i_inValid = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (o_run) break;
      @(posedge CLK); #1;
    end
    chk("reached_compute", o_run, 1);
    #1 RST = 0;
    #1;
    chk("rst_outs", {o_inReady, o_wrEn, o_run, o_outValid, o_outLast,
                     o_busy, o_frameDone, o_wrAddr, o_rdAddr, o_frameCnt}, 0);
    wr_q.delete(); rd_q.delete(); done_q.delete();
    fcnt_m = 0;
    i_inValid = 0;
    @(posedge CLK);
    @(negedge CLK) RST = 1;
    begin
      int nrun, nbusy;
      nrun = 0; nbusy = 0;
      repeat (10) begin
        @(negedge CLK);
        if (o_run) nrun++;
        if (o_busy) nbusy++;
      end
      chk("post_rst_run", nrun, 0);
      chk("post_rst_busy", nbusy, 0);
    end

    // 256 frames wrap the counter; noise starts while busy are ignored
    for (int f = 0; f < 256; f++) frame(f % 16 == 0, 0, 1);
    chk("fcnt_wrap", o_frameCnt, 0);
    chk("queues_empty", wr_q.size() + rd_q.size() + done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft32_seq_ctrl.md
FFT32_SEQ_CTRL -- requirements
Module: fft32_seq_ctrl

Interface
REQ-001 Parameter: p_points, default 32, number of points per frame; load, unload and address counts all use it.
REQ-002 Parameter: p_addrBits, default 5, sample and result address width (log2 of p_points).
REQ-003 Parameter: p_latency, default 4, number of register stages in the butterfly pipeline (1..15).
REQ-004 Parameter: p_bitRev, default 1; 1 = o_rdAddr bit-reversed, 0 = natural order.
REQ-005 Parameter: p_frameBits, default 8, frame counter width.
REQ-006 Port: CLK  input  1  system clock; all state changes on the rising edge.
REQ-007 Port: RST  input  1  reset, asynchronous, active-low.
REQ-008 Port: i_start  input  1  one-cycle request to accept a new frame.
REQ-009 Port: i_abort  input  1  synchronous abort of the current frame.
REQ-010 Port: i_inValid  input  1  input sample present.
REQ-011 Port: o_inReady  output  1  controller accepts a sample this cycle.
REQ-012 Port: o_wrEn  output  1  write strobe to the input sample register file.
REQ-013 Port: o_wrAddr  output  p_addrBits  write address for the sample.
REQ-014 Port: o_run  output  1  clock-enable to the butterfly stage pipeline.
REQ-015 Port: o_rdAddr  output  p_addrBits  result select into the last-stage outputs.
REQ-016 Port: o_outValid  output  1  result word on the output is valid.
REQ-017 Port: i_outReady  input  1  downstream accepts the result word.
REQ-018 Port: o_outLast  output  1  current result is the last of the frame.
REQ-019 Port: o_busy  output  1  controller state is not IDLE.
REQ-020 Port: o_frameDone  output  1  one-cycle pulse after a frame completes.
REQ-021 Port: o_frameCnt  output  p_frameBits  number of completed frames, modulo 2^p_frameBits.

Function
REQ-022 States SHALL be IDLE, LOAD, COMPUTE and UNLOAD, with one shared counter cnt of p_addrBits bits (COMPUTE uses cnt for the latency count).
REQ-023 IDLE: i_start=1 -> LOAD with cnt=0; i_start SHALL be ignored in every other state.
REQ-024 LOAD: o_inReady=1; an accept is i_inValid&&o_inReady; on each accept o_wrEn=1 (combinational) and o_wrAddr=cnt, then cnt increments.
REQ-025 LOAD: the accept made with cnt=p_points-1 SHALL move the state to COMPUTE and clear cnt; if i_inValid=0 the state holds with no write.
REQ-026 COMPUTE: o_run=1 for exactly p_latency cycles, then -> UNLOAD with cnt=0; o_inReady=0.
REQ-027 UNLOAD: o_outValid=1; o_rdAddr=bit-reverse(cnt) when p_bitRev=1, otherwise o_rdAddr=cnt; o_outLast=(cnt==p_points-1).
REQ-028 UNLOAD: cnt advances only on i_outReady=1; o_outValid and o_rdAddr hold stable while i_outReady=0.
REQ-029 The last handshake SHALL move the state to IDLE, pulse o_frameDone for the next cycle, and increment o_frameCnt, wrapping from all-ones to 0.
REQ-030 o_busy=1 in LOAD, COMPUTE and UNLOAD.
REQ-031 o_run=0 outside COMPUTE, so pipeline contents freeze during UNLOAD.
REQ-032 i_abort=1 in any state SHALL give IDLE and cnt=0 next cycle; no o_frameDone pulse and no frame count change.
REQ-033 When i_abort coincides with an accept or the last handshake, abort wins: that handshake is void and the frame is not counted.
REQ-034 Combinational handshake outputs (o_wrEn, o_inReady, o_outValid) SHALL be 0 in the abort cycle.
REQ-035 i_start together with i_abort in IDLE: abort wins and the state stays IDLE.

Reset
REQ-036 RST=0 SHALL immediately force IDLE, cnt=0 and o_frameCnt=0, and drive o_frameDone, o_inReady, o_wrEn, o_run, o_outValid, o_outLast and o_busy to 0 with o_wrAddr=o_rdAddr=0.
REQ-037 Reset asserted mid-frame discards the frame; release is taken synchronously at the next edge, and the block then waits in IDLE for i_start.

Verification
REQ-038 Continuous i_inValid, i_outReady=1, p_latency=4: i_start -> 32 writes to addr 0..31, 4 cycles of o_run, reads o_rdAddr 0,16,8,24,...,31 with o_outLast on the 32nd, o_frameDone, o_frameCnt=1; 69 cycles from i_start to o_frameDone.
REQ-039 Random i_inValid gaps and i_outReady stalls -> exactly 32 writes and 32 reads; o_rdAddr stable during each stall.
REQ-040 i_abort at load sample 17 -> IDLE next cycle, o_frameCnt unchanged; a new i_start reloads from addr 0.
REQ-041 i_abort coinciding with the final output handshake -> no o_frameDone, o_frameCnt unchanged.
REQ-042 256 back-to-back frames -> o_frameCnt wraps to 0; i_start pulses sent during a busy frame are ignored.
REQ-043 RST pulse during COMPUTE -> all outputs 0 at once; no o_run after release until the next full load.
